// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC00000;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry instruction queue: the head drives the fetch outputs and the skid
// catches the one word that can land while the head is held.
module fetch_skid_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  enq_i,
    input  logic [DATA_WIDTH-1:0] enq_instr_i,
    input  logic [ADDR_WIDTH-1:0] enq_pc_i,
    input  logic                  consume_i,
    output logic                  head_valid_o,
    output logic [DATA_WIDTH-1:0] head_instr_o,
    output logic [ADDR_WIDTH-1:0] head_pc_o,
    output logic                  skid_valid_o
);

    logic                  head_valid_q, head_valid_d;
    logic [DATA_WIDTH-1:0] head_instr_q, head_instr_d;
    logic [ADDR_WIDTH-1:0] head_pc_q,    head_pc_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] skid_instr_q, skid_instr_d;
    logic [ADDR_WIDTH-1:0] skid_pc_q,    skid_pc_d;

    // Consume first (skid slides into the head), then the new word takes the
    // first free slot, so consume+enqueue with a full skid refills the skid.
    always_comb begin
        head_valid_d = head_valid_q;
        head_instr_d = head_instr_q;
        head_pc_d    = head_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if (flush_i) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (consume_i) begin
                head_valid_d = skid_valid_q;
                head_instr_d = skid_instr_q;
                head_pc_d    = skid_pc_q;
                skid_valid_d = 1'b0;
            end
            if (enq_i) begin
                if (!head_valid_d) begin
                    head_valid_d = 1'b1;
                    head_instr_d = enq_instr_i;
                    head_pc_d    = enq_pc_i;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_instr_d = enq_instr_i;
                    skid_pc_d    = enq_pc_i;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_valid_q <= 1'b0;
            head_instr_q <= '0;
            head_pc_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            head_valid_q <= head_valid_d;
            head_instr_q <= head_instr_d;
            head_pc_q    <= head_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign head_valid_o = head_valid_q;
    assign head_instr_o = head_instr_q;
    assign head_pc_o    = head_pc_q;
    assign skid_valid_o = skid_valid_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, keeps one imem read in flight, buffers returned
// words and applies taken-branch redirects from the control unit.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  PCsrc,
    input  logic [ADDR_WIDTH-1:0] ImmOp,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid
);

    localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(INSTR_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(INSTR_BYTES - 1);

    fetch_state_t          state_q;
    logic [ADDR_WIDTH-1:0] fetch_pc_q;
    logic                  run_q;
    logic                  skid_valid;
    logic                  consume;
    logic                  redirect;
    logic                  issue;
    logic                  enq;
    logic [ADDR_WIDTH-1:0] target;

    assign consume  = instr_valid & ~stall;
    assign redirect = consume & PCsrc;
    assign target   = (instr_pc + ImmOp) & ALIGN_MASK;

    // The request strobe is decoded from the S_REQ state so a word returning
    // with one cycle of latency lets the next request go out right after it;
    // run_q keeps the strobe low while reset is held.
    assign issue     = run_q & (state_q == S_REQ) & ~skid_valid & ~redirect;
    assign imem_req  = issue;
    assign imem_addr = issue ? fetch_pc_q : '0;
    assign enq       = (state_q == S_WAIT) & imem_rvalid & ~redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC;
            run_q      <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (redirect) begin
                fetch_pc_q <= target;
            end else if (issue) begin
                fetch_pc_q <= fetch_pc_q + STEP;
            end
            case (state_q)
                S_REQ: begin
                    if (issue) state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid)   state_q <= S_REQ;
                    else if (redirect) state_q <= S_DROP;
                end
                S_DROP: begin
                    if (imem_rvalid) state_q <= S_REQ;
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

    fetch_skid_buffer #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (redirect),
        .enq_i       (enq),
        .enq_instr_i (imem_rdata),
        .enq_pc_i    (fetch_pc_q - STEP),
        .consume_i   (consume),
        .head_valid_o(instr_valid),
        .head_instr_o(instr),
        .head_pc_o   (instr_pc),
        .skid_valid_o(skid_valid)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a scoreboarded memory responder.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] DATA_KEY = 32'hA5A55A5A;
    localparam logic [31:0] RST_PC   = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        PCsrc;
    logic [31:0] ImmOp;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;

    int checks    = 0;
    int failures  = 0;
    int reqCount  = 0;
    int rdelay    = 1;
    int reqBefore = 0;

    logic [31:0] expAddrQ[$];
    logic [31:0] expPcQ[$];
    logic [5:0]  reqPattern;

    logic        memReqSeen;
    logic [31:0] memReqAddr;
    logic        memPending;
    logic [31:0] memPendAddr;
    int          memCnt;

    instr_fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .PCsrc      (PCsrc),
        .ImmOp      (ImmOp),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic p, input logic [31:0] imm);
        stall = s;
        PCsrc = p;
        ImmOp = imm;
    endtask

    task automatic doReset(input int hold);
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("reset_instr_valid", 32'(instr_valid), 32'h0);
        checkOutput("reset_imem_req", 32'(imem_req), 32'h0);
        checkOutput("reset_instr", instr, 32'h0);
        checkOutput("reset_instr_pc", instr_pc, 32'h0);
        repeat (hold) stepCycle();
        rst_n = 1'b1;
    endtask

    task automatic waitHead(input logic [31:0] pc, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            stepCycle();
            if (instr_valid === 1'b1 && instr_pc === pc) found = 1'b1;
        end
        checkOutput({"head_pc_", tag}, instr_pc, pc);
        checkOutput({"head_valid_", tag}, 32'(instr_valid), 32'h1);
    endtask

    // Memory model: a request seen mid-cycle returns addr^DATA_KEY after rdelay cycles.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        memPending  = 1'b0;
        memPendAddr = '0;
        memCnt      = 0;
        forever begin
            @(negedge clk);
            memReqSeen = imem_req;
            memReqAddr = imem_addr;
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (memReqSeen === 1'b1) begin
                memPending  = 1'b1;
                memPendAddr = memReqAddr;
                memCnt      = rdelay;
            end
            if (memPending) begin
                if (memCnt <= 1) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = memPendAddr ^ DATA_KEY;
                    memPending  = 1'b0;
                end else begin
                    memCnt--;
                end
            end
        end
    end

    // Scoreboard: every request and every consumed head must match the queues.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (imem_req === 1'b1) begin
                reqCount++;
                checkOutput("req_expected", 32'(expAddrQ.size() != 0), 32'h1);
                if (expAddrQ.size() != 0) checkOutput("imem_addr", imem_addr, expAddrQ.pop_front());
            end
            if (instr_valid === 1'b1 && stall === 1'b0) begin
                checkOutput("instr_expected", 32'(expPcQ.size() != 0), 32'h1);
                if (expPcQ.size() != 0) begin
                    logic [31:0] pc;
                    pc = expPcQ.pop_front();
                    checkOutput("instr_pc", instr_pc, pc);
                    checkOutput("instr", instr, pc ^ DATA_KEY);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        doReset(2);

        // Sequential prefetch with one-cycle memory latency.
        expAddrQ.push_back(RST_PC);
        expAddrQ.push_back(RST_PC + 32'h4);
        expAddrQ.push_back(RST_PC + 32'h8);
        expPcQ.push_back(RST_PC);
        expPcQ.push_back(RST_PC + 32'h4);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            reqPattern[i] = imem_req;
        end
        checkOutput("alt_req_pattern", 32'(reqPattern), 32'h2A);
        stepCycle();
        doReset(2);

        // Stall with head valid: one extra request fills the skid, then idle.
        expAddrQ.push_back(RST_PC);
        expAddrQ.push_back(RST_PC + 32'h4);
        expPcQ.push_back(RST_PC);
        expPcQ.push_back(RST_PC + 32'h4);
        expPcQ.push_back(RST_PC + 32'h8);
        waitHead(RST_PC, "t2_first");
        applyStimulus(1'b1, 1'b0, 32'h0);
        reqBefore = reqCount;
        for (int i = 0; i < 6; i++) begin
            checkOutput("t2_stall_pc", instr_pc, RST_PC);
            checkOutput("t2_stall_instr", instr, RST_PC ^ DATA_KEY);
            stepCycle();
        end
        checkOutput("t2_one_req", 32'(reqCount - reqBefore), 32'h1);
        checkOutput("t2_skid_full", 32'(dut.skid_valid), 32'h1);
        checkOutput("t2_req_idle", 32'(imem_req), 32'h0);
        expAddrQ.push_back(RST_PC + 32'h8);
        expAddrQ.push_back(RST_PC + 32'hC);
        applyStimulus(1'b0, 1'b0, 32'h0);
        waitHead(RST_PC + 32'h4, "t2_promoted");
        checkOutput("t2_skid_empty", 32'(dut.skid_valid), 32'h0);

        // Redirect while a request is outstanding: the late word is dropped.
        waitHead(RST_PC + 32'h8, "t3_branch");
        rdelay = 3;
        applyStimulus(1'b1, 1'b0, 32'h0);
        stepCycle();
        applyStimulus(1'b0, 1'b1, 32'hFFFFFFF8);
        expAddrQ.push_back(RST_PC);
        expPcQ.push_back(RST_PC);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        rdelay = 1;
        #1;
        checkOutput("t3_state_drop", 32'(dut.state_q), 32'(S_DROP));
        checkOutput("t3_flushed", 32'(instr_valid), 32'h0);
        checkOutput("t3_no_req_in_drop", 32'(imem_req), 32'h0);
        waitHead(RST_PC, "t3_target");

        // Redirect to 0x100, then a redirect coinciding with rvalid.
        applyStimulus(1'b0, 1'b1, 32'h100 - RST_PC);
        expAddrQ.push_back(32'h100);
        expAddrQ.push_back(32'h104);
        expAddrQ.push_back(32'h104);
        expPcQ.push_back(32'h100);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        waitHead(32'h100, "t4_head");
        applyStimulus(1'b1, 1'b0, 32'h0);
        stepCycle();
        applyStimulus(1'b0, 1'b1, 32'h6);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("t4_no_drop", 32'(dut.state_q), 32'(S_REQ));
        waitHead(32'h104, "t4_target");

        // Reset with a request in flight; its late data must be ignored.
        rdelay = 3;
        applyStimulus(1'b1, 1'b0, 32'h0);
        expAddrQ.push_back(32'h108);
        stepCycle();
        checkOutput("t5_state_wait", 32'(dut.state_q), 32'(S_WAIT));
        checkOutput("t5_head_before_reset", 32'(instr_valid), 32'h1);
        doReset(1);
        rdelay = 1;
        expAddrQ.push_back(RST_PC);
        expPcQ.push_back(RST_PC);
        waitHead(RST_PC, "t5_first");

        // Redirect to the top word and wrap the sequential PC to zero.
        applyStimulus(1'b0, 1'b1, 32'hFFFFFFFC - RST_PC);
        expAddrQ.push_back(32'hFFFFFFFC);
        expAddrQ.push_back(32'h00000000);
        expPcQ.push_back(32'hFFFFFFFC);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        waitHead(32'hFFFFFFFC, "t6_last");
        waitHead(32'h00000000, "t6_wrap");
        applyStimulus(1'b1, 1'b0, 32'h0);
        expAddrQ.push_back(32'h00000004);
        repeat (3) stepCycle();
        checkOutput("t6_hold_pc", instr_pc, 32'h0);
        checkOutput("t6_hold_instr", instr, 32'h0 ^ DATA_KEY);
        checkOutput("addr_queue_drained", 32'(expAddrQ.size()), 32'h0);
        checkOutput("pc_queue_drained", 32'(expPcQ.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
